// File: rtl/tristate_bus_rx.sv
// Receiver for a shared tristate bus: captures strobed words into a first-word
// fall-through FIFO and measures the length of each strobe burst.
module tristate_bus_rx #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         bus_data,
  input  logic                     bus_strobe,
  input  logic                     rd_en,
  input  logic                     ovf_clr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     burst_done,
  output logic [3:0]               burst_len
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {IDLE, RECV} state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             overflow_reg;

  state_t           state_reg, state_next;
  logic [3:0]       len_reg, len_next;
  logic [3:0]       burst_len_reg, burst_len_next;
  logic             burst_done_reg, burst_done_next;

  logic             full_w, empty_w, pop, push, drop;

  assign full_w  = (count_reg == DEPTH_C);
  assign empty_w = (count_reg == '0);
  assign pop     = rd_en && !empty_w;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push    = bus_strobe && (!full_w || pop);
  assign drop    = bus_strobe && full_w && !pop;

  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem[wr_ptr_reg] <= bus_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // Setting on a drop takes precedence over a coincident clear.
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (ovf_clr) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      len_reg        <= '0;
      burst_len_reg  <= '0;
      burst_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      len_reg        <= len_next;
      burst_len_reg  <= burst_len_next;
      burst_done_reg <= burst_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    len_next        = len_reg;
    burst_len_next  = burst_len_reg;
    burst_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus_strobe) begin
          state_next = RECV;
          len_next   = 4'd1;
        end
      end
      RECV: begin
        // Dropped words still count toward the burst length.
        if (bus_strobe) begin
          if (len_reg != 4'd15) begin
            len_next = len_reg + 4'd1;
          end
        end else begin
          state_next      = IDLE;
          burst_len_next  = len_reg;
          burst_done_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rd_data    = empty_w ? '0 : mem[rd_ptr_reg];
  assign rd_valid   = !empty_w;
  assign full       = full_w;
  assign count      = count_reg;
  assign overflow   = overflow_reg;
  assign burst_done = burst_done_reg;
  assign burst_len  = burst_len_reg;

endmodule

// File: tb/tb_tristate_bus_rx.sv
// Scoreboard bench for tristate_bus_rx: a queue model of the FIFO and a burst
// model are advanced with each stimulus cycle and compared against the DUT.
module tb_tristate_bus_rx;

  localparam int W = 2;
  localparam int D = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [W-1:0]     bus_data = '0;
  logic             bus_strobe = 1'b0;
  logic             rd_en = 1'b0;
  logic             ovf_clr = 1'b0;
  logic [W-1:0]     rd_data;
  logic             rd_valid;
  logic             full;
  logic [$clog2(D):0] count;
  logic             overflow;
  logic             burst_done;
  logic [3:0]       burst_len;

  int checks = 0;
  int failures = 0;

  // scoreboard / model state
  logic [W-1:0] sb[$];
  bit           m_ovf;
  bit           m_recv;
  int           m_len;
  int           m_blen;
  bit           m_bdone;
  bit           popped;
  logic [W-1:0] exp_pop, act_pop;

  tristate_bus_rx #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clk), .reset(reset), .bus_data(bus_data), .bus_strobe(bus_strobe),
    .rd_en(rd_en), .ovf_clr(ovf_clr), .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .count(count), .overflow(overflow), .burst_done(burst_done),
    .burst_len(burst_len)
  );

  always #5 clk = ~clk;

  // Drive one cycle on the falling edge, advance the model, sample 1 ns after the rising edge.
  task automatic step(input logic rst, input logic s, input logic [W-1:0] d,
                      input logic r, input logic c);
    int  size0;
    bit  pop, push, drop;
    @(negedge clk);
    reset = rst; bus_strobe = s; bus_data = d; rd_en = r; ovf_clr = c;
    popped = 1'b0;
    if (rst) begin
      sb.delete();
      m_ovf = 0; m_recv = 0; m_len = 0; m_blen = 0; m_bdone = 0;
    end else begin
      size0 = sb.size();
      pop  = r && (size0 > 0);
      if (pop) begin
        exp_pop = sb.pop_front();
        act_pop = rd_data;
        popped  = 1'b1;
      end
      push = s && ((size0 < D) || pop);
      drop = s && (size0 == D) && !pop;
      if (push) sb.push_back(d);
      if (drop) m_ovf = 1;
      else if (c) m_ovf = 0;
      m_bdone = 0;
      if (!m_recv) begin
        if (s) begin m_recv = 1; m_len = 1; end
      end else if (s) begin
        if (m_len < 15) m_len++;
      end else begin
        m_recv = 0; m_blen = m_len; m_bdone = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] exp_head();
    return (sb.size() > 0) ? sb[0] : '0;
  endfunction

  task automatic test_reset();
    step(1, 0, 0, 0, 0);
    step(1, 1, 3, 1, 0);
    checks += 7;
    if (count !== 0)      begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    if (rd_valid !== 0)   begin failures++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
    if (full !== 0)       begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
    if (rd_data !== 0)    begin failures++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
    if (overflow !== 0)   begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    if (burst_done !== 0) begin failures++; $display("FAIL reset_burst_done got=%0b exp=0", burst_done); end
    if (burst_len !== 0)  begin failures++; $display("FAIL reset_burst_len got=%0d exp=0", burst_len); end
    $display("test_reset done");
  endtask

  task automatic test_burst3();
    step(0, 1, 1, 0, 0);
    checks += 2;
    if (rd_data !== 2'd1) begin failures++; $display("FAIL b3_first_word got=%0d exp=1", rd_data); end
    if (rd_valid !== 1)   begin failures++; $display("FAIL b3_rd_valid got=%0b exp=1", rd_valid); end
    step(0, 1, 2, 0, 0);
    step(0, 1, 3, 0, 0);
    checks += 2;
    if (count !== 3)      begin failures++; $display("FAIL b3_count got=%0d exp=3", count); end
    if (burst_done !== 0) begin failures++; $display("FAIL b3_early_done got=%0b exp=0", burst_done); end
    step(0, 0, 0, 0, 0);
    checks += 2;
    if (burst_done !== 1) begin failures++; $display("FAIL b3_done got=%0b exp=1", burst_done); end
    if (burst_len !== 4'd3) begin failures++; $display("FAIL b3_len got=%0d exp=3", burst_len); end
    step(0, 0, 0, 0, 0);
    checks++;
    if (burst_done !== 0) begin failures++; $display("FAIL b3_done_pulse got=%0b exp=0", burst_done); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0);
      checks++;
      if (!popped || act_pop !== exp_pop) begin
        failures++; $display("FAIL b3_pop%0d got=%0d exp=%0d", i, act_pop, exp_pop);
      end
    end
    $display("test_burst3 done count=%0d", count);
  endtask

  task automatic test_overflow();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, W'(i), 0, 0);
    step(0, 0, 0, 0, 0);
    checks += 5;
    if (full !== 1)       begin failures++; $display("FAIL ovf_full got=%0b exp=1", full); end
    if (overflow !== 1)   begin failures++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
    if (count !== 4)      begin failures++; $display("FAIL ovf_count got=%0d exp=4", count); end
    if (burst_len !== 4'd5) begin failures++; $display("FAIL ovf_len got=%0d exp=5", burst_len); end
    if (rd_data !== 2'd0) begin failures++; $display("FAIL ovf_head got=%0d exp=0", rd_data); end
    $display("test_overflow done overflow=%0b", overflow);
  endtask

  task automatic test_full_push_pop();
    step(0, 1, 2, 1, 0);
    checks += 4;
    if (!popped || act_pop !== 2'd0) begin failures++; $display("FAIL fpp_pop got=%0d exp=0", act_pop); end
    if (count !== 4)     begin failures++; $display("FAIL fpp_count got=%0d exp=4", count); end
    if (overflow !== 1)  begin failures++; $display("FAIL fpp_overflow got=%0b exp=1", overflow); end
    if (rd_data !== 2'd1) begin failures++; $display("FAIL fpp_head got=%0d exp=1", rd_data); end
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0);
      checks++;
      if (!popped || act_pop !== exp_pop) begin
        failures++; $display("FAIL fpp_drain%0d got=%0d exp=%0d", i, act_pop, exp_pop);
      end
    end
    checks++;
    if (rd_valid !== 0) begin failures++; $display("FAIL fpp_empty got=%0b exp=0", rd_valid); end
    $display("test_full_push_pop done");
  endtask

  task automatic test_ovf_clr();
    step(0, 0, 0, 0, 1);
    checks++;
    if (overflow !== 0) begin failures++; $display("FAIL clr_overflow got=%0b exp=0", overflow); end
    for (int i = 0; i < 4; i++) step(0, 1, W'(3 - i), 0, 0);
    checks++;
    if (overflow !== 0) begin failures++; $display("FAIL clr_fill_no_ovf got=%0b exp=0", overflow); end
    step(0, 1, 1, 0, 1);
    checks++;
    if (overflow !== 1) begin failures++; $display("FAIL clr_set_wins got=%0b exp=1", overflow); end
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    $display("test_ovf_clr done");
  endtask

  task automatic test_empty_read();
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 1, 0);
      checks += 3;
      if (count !== 0)    begin failures++; $display("FAIL er_count got=%0d exp=0", count); end
      if (rd_valid !== 0) begin failures++; $display("FAIL er_rd_valid got=%0b exp=0", rd_valid); end
      if (rd_data !== 0)  begin failures++; $display("FAIL er_rd_data got=%0d exp=0", rd_data); end
    end
    $display("test_empty_read done");
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) step(0, 1, W'(i), 0, 0);
    step(0, 0, 0, 0, 0);
    checks += 2;
    if (burst_len !== 4'd15) begin failures++; $display("FAIL sat_len got=%0d exp=15", burst_len); end
    if (burst_done !== 1)    begin failures++; $display("FAIL sat_done got=%0b exp=1", burst_done); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0);
      checks++;
      if (!popped || act_pop !== exp_pop) begin
        failures++; $display("FAIL sat_pop%0d got=%0d exp=%0d", i, act_pop, exp_pop);
      end
    end
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) step(0, 1, W'(i), 0, 0);
    step(1, 1, 3, 0, 0);
    checks += 7;
    if (count !== 0)      begin failures++; $display("FAIL abort_count got=%0d exp=0", count); end
    if (rd_valid !== 0)   begin failures++; $display("FAIL abort_rd_valid got=%0b exp=0", rd_valid); end
    if (full !== 0)       begin failures++; $display("FAIL abort_full got=%0b exp=0", full); end
    if (rd_data !== 0)    begin failures++; $display("FAIL abort_rd_data got=%0d exp=0", rd_data); end
    if (overflow !== 0)   begin failures++; $display("FAIL abort_overflow got=%0b exp=0", overflow); end
    if (burst_done !== 0) begin failures++; $display("FAIL abort_done got=%0b exp=0", burst_done); end
    if (burst_len !== 0)  begin failures++; $display("FAIL abort_len got=%0d exp=0", burst_len); end
    step(0, 0, 0, 0, 0);
    checks++;
    if (burst_done !== 0) begin failures++; $display("FAIL abort_no_pulse got=%0b exp=0", burst_done); end
    $display("test_saturate done");
  endtask

  task automatic test_back_to_back();
    logic s, r, c;
    logic [W-1:0] d;
    for (int i = 0; i < 200; i++) begin
      s = 1'($urandom_range(0, 99) < 65);
      r = 1'($urandom_range(0, 99) < 50);
      c = 1'($urandom_range(0, 99) < 10);
      d = W'($urandom);
      step(0, s, d, r, c);
      checks += 5;
      if (popped && act_pop !== exp_pop) begin
        failures++; $display("FAIL b2b_pop cyc=%0d got=%0d exp=%0d", i, act_pop, exp_pop);
      end
      if (count !== sb.size()) begin
        failures++; $display("FAIL b2b_count cyc=%0d got=%0d exp=%0d", i, count, sb.size());
      end
      if (rd_data !== exp_head()) begin
        failures++; $display("FAIL b2b_head cyc=%0d got=%0d exp=%0d", i, rd_data, exp_head());
      end
      if (overflow !== m_ovf) begin
        failures++; $display("FAIL b2b_overflow cyc=%0d got=%0b exp=%0b", i, overflow, m_ovf);
      end
      if (burst_done !== m_bdone || burst_len !== 4'(m_blen)) begin
        failures++; $display("FAIL b2b_burst cyc=%0d got=%0b/%0d exp=%0b/%0d",
                             i, burst_done, burst_len, m_bdone, m_blen);
      end
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_burst3();
    test_overflow();
    test_full_push_pop();
    test_ovf_clr();
    test_empty_read();
    test_saturate();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
